// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: prefetch FSM states, NOP encoding, default reset PC.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PFQ_IDLE = 2'b00,
    PFQ_WAIT = 2'b01,
    PFQ_DROP = 2'b10
  } pfq_state_e;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
  localparam logic [31:0] PFQ_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Ring buffer of {pc+4, instr} pairs for the prefetch queue; flush clears pointers and count.
module pfq_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [63:0]              head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push   = push & (count != CW'(DEPTH)) & ~flush;
  assign do_pop    = pop & (count != '0) & ~flush;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front end: req/ack instruction fetch, prefetch FIFO into IF/ID, redirect flush.
// Optional macro PFQ_BYPASS_EN forwards an ack straight to IF/ID when the queue is empty.
module instr_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = PFQ_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pfq_state_e    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [63:0]   head_data;
  logic          pending;
  logic          credit;
  logic          fifo_valid;
  logic          bypass;
  logic          push;
  logic          pop;

  assign pending     = (state == PFQ_WAIT);
  assign outstanding = count + {{(CW-1){1'b0}}, pending};
  assign credit      = outstanding < CW'(DEPTH);
  assign fifo_valid  = (count != '0);

`ifdef PFQ_BYPASS_EN
  assign bypass = (state == PFQ_WAIT) & mem_ack_i & ~fifo_valid & instr_ready_i & ~redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = (state == PFQ_WAIT) & mem_ack_i & ~redirect_i & ~bypass;
  assign pop  = fifo_valid & instr_ready_i & ~redirect_i;

  pfq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc + 32'd4, mem_data_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (count),
    .head_data (head_data)
  );

  always_comb begin
    instr_valid_o = fifo_valid;
    instr_o       = fifo_valid ? head_data[31:0]  : INSTR_NOP;
    pc_plus4_o    = fifo_valid ? head_data[63:32] : '0;
    if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = mem_data_i;
      pc_plus4_o    = fetch_pc + 32'd4;
    end
  end

  // Redirect always wins; an outstanding request cannot be cancelled, so it is parked in DROP.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= PFQ_IDLE;
      fetch_pc   <= RESET_PC;
      mem_req_o  <= 1'b0;
      mem_addr_o <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= word_align(redirect_pc_i);
      case (state)
        PFQ_WAIT, PFQ_DROP: begin
          if (mem_ack_i) begin
            state     <= PFQ_IDLE;
            mem_req_o <= 1'b0;
          end else begin
            state <= PFQ_DROP;
          end
        end
        default: state <= PFQ_IDLE;
      endcase
    end else begin
      case (state)
        PFQ_IDLE: begin
          if (credit) begin
            state      <= PFQ_WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_pc;
          end
        end
        PFQ_WAIT: begin
          if (mem_ack_i) begin
            state     <= PFQ_IDLE;
            mem_req_o <= 1'b0;
            fetch_pc  <= fetch_pc + 32'd4;
          end
        end
        PFQ_DROP: begin
          if (mem_ack_i) begin
            state     <= PFQ_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= PFQ_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue; honours PFQ_BYPASS_EN if defined.
module tb_instr_prefetch_queue;

  logic        clk_i;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int checks = 0;
  int errors = 0;
  int bad_seen = 0;

  // Memory model: automatic ack after lat waiting cycles, or manual ack with chosen data.
  logic        auto_en;
  int unsigned lat;
  int unsigned wcnt;
  logic        man_ack;
  logic [31:0] man_data;

  instr_prefetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign mem_ack_i  = man_ack | (auto_en & (mem_req_o === 1'b1) & (wcnt == lat));
  assign mem_data_i = man_ack ? man_data : ~mem_addr_o;

  always @(posedge clk_i) begin
    if (mem_req_o !== 1'b1 || mem_ack_i) wcnt <= 0;
    else                                 wcnt <= wcnt + 1;
  end

  always @(negedge clk_i) begin
    if (instr_valid_o === 1'b1 && instr_o === 32'hDEAD_BEEF) bad_seen++;
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    auto_en = 1'b0; lat = 0; man_ack = 1'b0; man_data = '0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    cyc();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", mem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr_o); end
    checks++; if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 00000000", pc_plus4_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int got = 0;
    int last = -1;
    logic [31:0] exp_pc4;
    do_reset();
    auto_en = 1'b1; lat = 0; instr_ready_i = 1'b1;
    for (int i = 0; i < 40 && got < 3; i++) begin
      cyc();
      if (instr_valid_o === 1'b1) begin
        exp_pc4 = 32'(got * 4 + 4);
        checks++; if (pc_plus4_o !== exp_pc4) begin errors++; $display("FAIL stream_pc4 got %h want %h", pc_plus4_o, exp_pc4); end
        checks++; if (instr_o !== ~(exp_pc4 - 32'd4)) begin errors++; $display("FAIL stream_instr got %h want %h", instr_o, ~(exp_pc4 - 32'd4)); end
        if (last >= 0) begin
          checks++; if (i - last != 2) begin errors++; $display("FAIL stream_gap got %0d want 2", i - last); end
        end
        last = i;
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL stream_count got %0d want 3", got); end
  endtask

  task automatic test_stall();
    int req_seen = 0;
    do_reset();
    auto_en = 1'b1; lat = 1; instr_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i >= 14 && mem_req_o !== 1'b0) req_seen++;
    end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL stall_req got %0d want 0", req_seen); end
    checks++; if (instr_valid_o !== 1'b1 || pc_plus4_o !== 32'h4) begin
      errors++; $display("FAIL stall_head got %b/%h want 1/00000004", instr_valid_o, pc_plus4_o); end
    instr_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (instr_valid_o !== 1'b1 || pc_plus4_o !== 32'(4 * j + 4)) begin
        errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", j, instr_valid_o, pc_plus4_o, 32'(4 * j + 4)); end
      cyc();
    end
  endtask

  task automatic test_redirect_wait();
    int found = 0;
    do_reset();
    instr_ready_i = 1'b1;
    cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rw_first_req got %b/%h want 1/00000000", mem_req_o, mem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    cyc();
    redirect_i = 1'b0;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rw_hold got %b/%h want 1/00000000", mem_req_o, mem_addr_o); end
    cyc(); cyc();
    man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
    cyc();
    man_ack = 1'b0;
    auto_en = 1'b1; lat = 0;
    for (int i = 0; i < 10 && mem_req_o !== 1'b1; i++) cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      errors++; $display("FAIL rw_new_req got %b/%h want 1/00000100", mem_req_o, mem_addr_o); end
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (instr_valid_o === 1'b1) begin
        found = 1;
        checks++; if (pc_plus4_o !== 32'h104 || instr_o !== 32'hFFFF_FEFF) begin
          errors++; $display("FAIL rw_first_out got %h/%h want 00000104/fffffeff", pc_plus4_o, instr_o); end
      end else cyc();
    end
    checks++; if (found != 1) begin errors++; $display("FAIL rw_timeout got %0d want 1", found); end
    checks++; if (bad_seen != 0) begin errors++; $display("FAIL rw_stale_out got %0d want 0", bad_seen); end
  endtask

  task automatic test_redirect_ack();
    int found = 0;
    do_reset();
    auto_en = 1'b1; lat = 0; instr_ready_i = 1'b0;
    for (int i = 0; i < 20 && !(mem_req_o === 1'b0 && mem_addr_o === 32'h4); i++) cyc();
    auto_en = 1'b0;
    cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8 || instr_valid_o !== 1'b1) begin
      errors++; $display("FAIL ra_setup got %b/%h/%b want 1/00000008/1", mem_req_o, mem_addr_o, instr_valid_o); end
    man_ack = 1'b1; man_data = 32'h1234_5678;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    cyc();
    man_ack = 1'b0; redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL ra_flush got %b/%b want 0/0", instr_valid_o, mem_req_o); end
    cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      errors++; $display("FAIL ra_new_req got %b/%h want 1/00000200", mem_req_o, mem_addr_o); end
    auto_en = 1'b1; instr_ready_i = 1'b1;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (instr_valid_o === 1'b1) begin
        found = 1;
        checks++; if (pc_plus4_o !== 32'h204 || instr_o !== 32'hFFFF_FDFF) begin
          errors++; $display("FAIL ra_first_out got %h/%h want 00000204/fffffdff", pc_plus4_o, instr_o); end
      end else cyc();
    end
    checks++; if (found != 1) begin errors++; $display("FAIL ra_timeout got %0d want 1", found); end
  endtask

  task automatic test_wrap();
    int found = 0;
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_idle got %b want 0", mem_req_o); end
    auto_en = 1'b1; lat = 0; instr_ready_i = 1'b1;
    cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", mem_req_o, mem_addr_o); end
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (instr_valid_o === 1'b1) begin
        found = 1;
        checks++; if (pc_plus4_o !== 32'h0 || instr_o !== 32'h3) begin
          errors++; $display("FAIL wrap_out got %h/%h want 00000000/00000003", pc_plus4_o, instr_o); end
      end else cyc();
    end
    checks++; if (found != 1) begin errors++; $display("FAIL wrap_timeout got %0d want 1", found); end
    for (int i = 0; i < 10 && mem_req_o === 1'b1; i++) cyc();
    for (int i = 0; i < 10 && mem_req_o !== 1'b1; i++) cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_next_req got %b/%h want 1/00000000", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    cyc();
    redirect_i = 1'b0;
    cyc();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
      errors++; $display("FAIL rm_setup got %b/%h want 1/00000040", mem_req_o, mem_addr_o); end
    rst_n = 1'b0;
    cyc();
    checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
      errors++; $display("FAIL rm_in_reset got %b/%h/%b/%h/%h want 0/00000000/0/00000000/00000000",
                         mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_plus4_o); end
    rst_n = 1'b1; man_ack = 1'b1; man_data = 32'hBAD0_BAD0;
    cyc();
    man_ack = 1'b0;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rm_first_req got %b/%h want 1/00000000", mem_req_o, mem_addr_o); end
    cyc();
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1) begin
      errors++; $display("FAIL rm_stale_ack got %b/%b want 0/1", instr_valid_o, mem_req_o); end
    man_ack = 1'b1; man_data = 32'h1111_1111;
    cyc();
    man_ack = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || pc_plus4_o !== 32'h4 || instr_o !== 32'h1111_1111) begin
      errors++; $display("FAIL rm_first_out got %b/%h/%h want 1/00000004/11111111", instr_valid_o, pc_plus4_o, instr_o); end
  endtask

  task automatic test_bypass();
    do_reset();
    instr_ready_i = 1'b1;
    cyc();
    man_ack = 1'b1; man_data = 32'h2008_0005;
    #1;
`ifdef PFQ_BYPASS_EN
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h2008_0005 || pc_plus4_o !== 32'h4) begin
      errors++; $display("FAIL bypass_same got %b/%h/%h want 1/20080005/00000004", instr_valid_o, instr_o, pc_plus4_o); end
`else
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_same got %b want 0", instr_valid_o); end
`endif
    cyc();
    man_ack = 1'b0;
`ifdef PFQ_BYPASS_EN
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_next got %b want 0", instr_valid_o); end
`else
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h2008_0005 || pc_plus4_o !== 32'h4) begin
      errors++; $display("FAIL bypass_next got %b/%h/%h want 1/20080005/00000004", instr_valid_o, instr_o, pc_plus4_o); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; auto_en = 1'b0; lat = 0; man_ack = 1'b0; man_data = '0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
